// File: rtl/data_memory_responder.sv
// data_memory_responder: data-memory slave behind the memory-address stage.
// Word-organised synchronous RAM serving loads and stores; sub-word stores
// are completed as a read-modify-write that takes one extra cycle.
// Ports:
//   clock, reset_n     - clock, asynchronous active-low reset
//   memory_signals     - request bus (mem_enable, mem_en, address, data_in)
//   store_op           - store size, only meaningful with a write
//   data_out           - registered load data, always the full aligned word
//   ready              - request can be accepted this cycle
//   access_fault       - one-cycle pulse after a rejected request

package data_memory_pkg;

    typedef enum logic {
        MEM_READ_EN  = 1'b0,
        MEM_WRITE_EN = 1'b1
    } mem_en_t;

    typedef enum logic [1:0] {
        STORE_BYTE  = 2'd0,
        STORE_HBYTE = 2'd1,
        STORE_WORD  = 2'd2
    } store_op_t;

    typedef struct packed {
        logic        mem_enable;
        mem_en_t     mem_en;
        logic [31:0] address;
        logic [31:0] data_in;
    } data_memory_interface_t;

endpackage

module data_memory_responder
    import data_memory_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  data_memory_interface_t memory_signals,
    input  store_op_t              store_op,
    output logic [31:0]            data_out,
    output logic                   ready,
    output logic                   access_fault
);

    localparam int unsigned AW         = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RMW  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     mem_q [DEPTH_WORDS];

    logic [31:0]     data_out_q, data_out_d;
    logic            access_fault_q, access_fault_d;
    logic [31:0]     rmw_word_q, rmw_word_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [1:0]      lane_q, lane_d;
    logic            half_q, half_d;
    logic [15:0]     lo_data_q, lo_data_d;

    logic [31:0]     offset_c;
    logic [AW-1:0]   idx_c;
    logic [1:0]      lane_c;
    logic            out_of_range_c;
    logic            is_write_c;
    logic            misalign_c;
    logic            fault_c;
    logic            subword_c;
    logic [31:0]     merged_c;
    logic            mem_we_c;
    logic [AW-1:0]   mem_waddr_c;
    logic [31:0]     mem_wdata_c;

    assign ready        = (state_q == S_IDLE);
    assign data_out     = data_out_q;
    assign access_fault = access_fault_q;

    // Address decode relative to the window base.
    assign offset_c       = memory_signals.address - BASE_ADDR;
    assign idx_c          = offset_c[AW+1:2];
    assign lane_c         = memory_signals.address[1:0];
    assign out_of_range_c = (offset_c >= SPAN_BYTES);
    assign is_write_c     = (memory_signals.mem_en == MEM_WRITE_EN);

    // Alignment rules apply to stores only; loads return the aligned word.
    // The unused store_op encoding is rejected rather than guessed at.
    always_comb begin
        misalign_c = 1'b0;
        if (is_write_c) begin
            case (store_op)
                STORE_BYTE:  misalign_c = 1'b0;
                STORE_HBYTE: misalign_c = lane_c[0];
                STORE_WORD:  misalign_c = (lane_c != 2'd0);
                default:     misalign_c = 1'b1;
            endcase
        end
    end

    assign fault_c   = out_of_range_c | misalign_c;
    assign subword_c = ready && memory_signals.mem_enable && !fault_c && is_write_c
                       && ((store_op == STORE_BYTE) || (store_op == STORE_HBYTE));

    // Captured word with the latched lane(s) replaced.
    always_comb begin
        merged_c = rmw_word_q;
        if (half_q) begin
            if (lane_q[1]) merged_c[31:16] = lo_data_q;
            else           merged_c[15:0]  = lo_data_q;
        end else begin
            merged_c[{lane_q, 3'b000} +: 8] = lo_data_q[7:0];
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (subword_c) state_d = S_RMW;
            S_RMW:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath logic.
    always_comb begin
        data_out_d     = data_out_q;
        access_fault_d = access_fault_q;
        rmw_word_d     = rmw_word_q;
        idx_d          = idx_q;
        lane_d         = lane_q;
        half_d         = half_q;
        lo_data_d      = lo_data_q;
        mem_we_c       = 1'b0;
        mem_waddr_c    = idx_c;
        mem_wdata_c    = memory_signals.data_in;
        case (state_q)
            S_IDLE: begin
                access_fault_d = 1'b0;
                if (memory_signals.mem_enable) begin
                    if (fault_c) begin
                        access_fault_d = 1'b1;
                        data_out_d     = 32'h0;
                    end else if (!is_write_c) begin
                        data_out_d = mem_q[idx_c];
                    end else if (store_op == STORE_WORD) begin
                        mem_we_c = 1'b1;
                    end else begin
                        idx_d      = idx_c;
                        lane_d     = lane_c;
                        half_d     = (store_op == STORE_HBYTE);
                        lo_data_d  = memory_signals.data_in[15:0];
                        rmw_word_d = mem_q[idx_c];
                    end
                end
            end
            S_RMW: begin
                access_fault_d = 1'b0;
                mem_we_c       = 1'b1;
                mem_waddr_c    = idx_q;
                mem_wdata_c    = merged_c;
            end
            default: access_fault_d = 1'b0;
        endcase
    end

    // Registered outputs and RMW context.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_out_q     <= 32'h0;
            access_fault_q <= 1'b0;
            rmw_word_q     <= 32'h0;
            idx_q          <= '0;
            lane_q         <= 2'd0;
            half_q         <= 1'b0;
            lo_data_q      <= 16'h0;
        end else begin
            data_out_q     <= data_out_d;
            access_fault_q <= access_fault_d;
            rmw_word_q     <= rmw_word_d;
            idx_q          <= idx_d;
            lane_q         <= lane_d;
            half_q         <= half_d;
            lo_data_q      <= lo_data_d;
        end
    end

    // RAM write port; contents are not reset, writes are blocked while in reset.
    always_ff @(posedge clock) begin
        if (reset_n && mem_we_c) mem_q[mem_waddr_c] <= mem_wdata_c;
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder: directed scenarios with
// literal expectations plus randomized traffic against a behavioural model.
module tb_data_memory_responder;
    import data_memory_pkg::*;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] SPAN  = 32'(DEPTH * 4);

    logic                   clock   = 1'b0;
    logic                   reset_n = 1'b0;
    data_memory_interface_t memory_signals;
    store_op_t              store_op;
    logic [31:0]            data_out;
    logic                   ready;
    logic                   access_fault;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clock = ~clock;

    data_memory_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .memory_signals (memory_signals),
        .store_op       (store_op),
        .data_out       (data_out),
        .ready          (ready),
        .access_fault   (access_fault)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem [DEPTH];
    bit          m_busy;
    logic [31:0] m_dout;
    bit          m_fault;
    bit          m_pend;
    logic [9:0]  m_pidx;
    logic [31:0] m_pval;
    logic [31:0] m_off;
    logic [9:0]  m_idx;
    int unsigned m_lane;
    int unsigned m_width;
    logic [31:0] m_mask;
    bit          m_wr;
    bit          m_bad;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_busy  = 1'b0;
            m_dout  = 32'h0;
            m_fault = 1'b0;
            m_pend  = 1'b0;
        end else begin
            if (m_pend) begin
                m_mem[m_pidx] = m_pval;
                m_pend = 1'b0;
            end
            if (m_busy) begin
                m_busy  = 1'b0;
                m_fault = 1'b0;
            end else if (!memory_signals.mem_enable) begin
                m_fault = 1'b0;
            end else begin
                m_off  = memory_signals.address - BASE;
                m_idx  = 10'(m_off / 4);
                m_lane = 32'(memory_signals.address % 4);
                m_wr   = (memory_signals.mem_en == MEM_WRITE_EN);
                m_bad  = (m_off >= SPAN);
                if (m_wr && store_op == STORE_HBYTE && (m_lane % 2) != 0) m_bad = 1'b1;
                if (m_wr && store_op == STORE_WORD && m_lane != 0)        m_bad = 1'b1;
                m_fault = m_bad;
                if (m_bad) begin
                    m_dout = 32'h0;
                end else if (!m_wr) begin
                    m_dout = m_mem[m_idx];
                end else if (store_op == STORE_WORD) begin
                    m_mem[m_idx] = memory_signals.data_in;
                end else begin
                    m_width = (store_op == STORE_BYTE) ? 8 : 16;
                    m_mask  = (32'hFFFF_FFFF >> (32 - m_width)) << (8 * m_lane);
                    m_pval  = (m_mem[m_idx] & ~m_mask)
                            | ((memory_signals.data_in << (8 * m_lane)) & m_mask);
                    m_pidx  = m_idx;
                    m_pend  = 1'b1;
                    m_busy  = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(posedge clock) begin
        #1;
        if (chk_en) begin
            check1 ("ready", ready, !m_busy);
            check32("data_out", data_out, m_dout);
            check1 ("access_fault", access_fault, m_fault);
        end
    end

    // ---------------- driver ----------------
    task automatic req(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input store_op_t op, output int waited);
        @(negedge clock);
        memory_signals.mem_enable = 1'b1;
        memory_signals.mem_en     = wr ? MEM_WRITE_EN : MEM_READ_EN;
        memory_signals.address    = addr;
        memory_signals.data_in    = data;
        store_op                  = op;
        waited = 0;
        while (ready !== 1'b1 && waited < 8) begin
            @(negedge clock);
            waited++;
        end
        if (ready !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL req_timeout: ready stuck at %b for addr %h", ready, addr);
        end
        @(posedge clock);
        #1;
        memory_signals.mem_enable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [31:0] vals [8];
        memory_signals = '0;
        store_op       = STORE_WORD;
        reset_n        = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check1 ("reset_ready", ready, 1'b1);
        check32("reset_data_out", data_out, 32'h0);
        check1 ("reset_fault", access_fault, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        chk_en  = 1'b1;

        // Initialise the region used by the rest of the run.
        for (int i = 0; i < 64; i++) req(1'b1, 32'(i * 4), $urandom, STORE_WORD, w);

        // Word round trip.
        req(1'b1, 32'h10, 32'hDEAD_BEEF, STORE_WORD, w);
        req(1'b0, 32'h10, 32'h0, STORE_WORD, w);
        check32("word_roundtrip", data_out, 32'hDEAD_BEEF);

        // Reset asserted mid-cycle acts immediately.
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check1 ("midreset_ready", ready, 1'b1);
        check32("midreset_data_out", data_out, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;

        // Byte merge.
        req(1'b1, 32'h20, 32'h1122_3344, STORE_WORD, w);
        req(1'b1, 32'h22, 32'h0000_00AA, STORE_BYTE, w);
        check1("byte_ready_low", ready, 1'b0);
        @(posedge clock);
        #1;
        check1("byte_ready_back", ready, 1'b1);
        req(1'b0, 32'h20, 32'h0, STORE_WORD, w);
        check32("byte_merge", data_out, 32'h11AA_3344);

        // Half merge with a load stalled behind the write-back.
        req(1'b1, 32'h24, 32'h1234_5678, STORE_WORD, w);
        req(1'b1, 32'h26, 32'h0000_BEEF, STORE_HBYTE, w);
        check1("half_ready_low", ready, 1'b0);
        req(1'b0, 32'h24, 32'h0, STORE_WORD, w);
        check32("half_stall_cycles", 32'(w), 32'd1);
        check32("half_merge", data_out, 32'hBEEF_5678);

        // Faults.
        req(1'b1, 32'h12, 32'hCAFE_F00D, STORE_WORD, w);
        check1 ("fault_word_pulse", access_fault, 1'b1);
        check32("fault_word_dout", data_out, 32'h0);
        req(1'b0, 32'h10, 32'h0, STORE_WORD, w);
        check1 ("fault_word_clear", access_fault, 1'b0);
        check32("fault_word_mem", data_out, 32'hDEAD_BEEF);
        req(1'b1, 32'h21, 32'h0000_5555, STORE_HBYTE, w);
        check1 ("fault_half_pulse", access_fault, 1'b1);
        req(1'b0, 32'h20, 32'h0, STORE_WORD, w);
        check32("fault_half_mem", data_out, 32'h11AA_3344);
        req(1'b0, BASE + SPAN, 32'h0, STORE_WORD, w);
        check1 ("fault_oor_pulse", access_fault, 1'b1);
        check32("fault_oor_dout", data_out, 32'h0);

        // Reset during the write-back cycle discards it.
        req(1'b1, 32'h30, 32'h0, STORE_WORD, w);
        req(1'b1, 32'h30, 32'h0000_00FF, STORE_BYTE, w);
        @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        check1("rmw_reset_ready", ready, 1'b1);
        @(negedge clock);
        reset_n = 1'b1;
        req(1'b0, 32'h30, 32'h0, STORE_WORD, w);
        check32("rmw_reset_mem", data_out, 32'h0);

        // Back-to-back throughput.
        for (int i = 0; i < 8; i++) begin
            vals[i] = $urandom;
            req(1'b1, 32'h40 + 32'(i * 4), vals[i], STORE_WORD, w);
            check1("b2b_store_ready", ready, 1'b1);
        end
        for (int i = 0; i < 8; i++) begin
            req(1'b0, 32'h40 + 32'(i * 4), 32'h0, STORE_WORD, w);
            check32("b2b_load_wait", 32'(w), 32'd0);
            check32("b2b_load", data_out, vals[i]);
        end

        // Randomized traffic; the every-cycle compare does the checking.
        for (int n = 0; n < 400; n++) begin
            int unsigned r;
            logic [31:0] a;
            store_op_t   op;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                @(negedge clock);
            end else begin
                a = 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
                if ($urandom_range(0, 9) == 0) a = BASE + SPAN + 32'($urandom_range(0, 255));
                op = store_op_t'($urandom_range(0, 2));
                req(r > 4, a, $urandom, op, w);
            end
        end

        @(negedge clock);
        @(negedge clock);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

- Data-memory slave at the far end of the `data_memory_interface_t` request bus driven by the memory-address stage.
- Holds a word-organised synchronous RAM and serves loads and stores from that bus.
- Sub-word stores are done as read-modify-write.
- Data is returned as a full aligned word; the memory-wait stage extracts the byte or half, so the responder never sign-extends.

## Interface
Parameters:
- `DEPTH_WORDS`, default 1024: number of 32-bit words; power of two, ≥ 4.
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0; aligned to `DEPTH_WORDS*4`.

Ports:
- `clock` in 1: single clock; all state changes on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `memory_signals` in `data_memory_interface_t`: request fields `mem_enable`, `mem_en` (MEM_READ_EN/MEM_WRITE_EN), `address`, `data_in`.
- `store_op` in `store_op_t`: store size (STORE_BYTE/STORE_HBYTE/STORE_WORD); sampled only with a write.
- `data_out` out 32: registered load data, the full aligned word.
- `ready` out 1: high when a request can be accepted; the pipeline drives its stage enables from it.
- `access_fault` out 1: one-cycle pulse for a rejected request.

## Operation
- **States:** IDLE, RMW. `ready = (state == IDLE)`, decoded from the state register.
- **Accept:** rising edge with `ready=1` and `mem_enable=1`. With `mem_enable=0` nothing changes except `access_fault`, which returns to 0.
- **Address decode:**
  - offset = `address - BASE_ADDR`; word index = offset[log2(DEPTH_WORDS)+1:2]; lane = `address[1:0]`.
  - Out of range when offset ≥ `DEPTH_WORDS*4`.
- **Fault check** (accept edge):
  - Faulting requests: out of range; STORE_HBYTE with `address[0]=1`; STORE_WORD with lane≠0; any read with out-of-range address.
  - On fault: `access_fault`←1 for one cycle, `data_out`←0, no array write, state stays IDLE.
  - Misaligned reads are not faulted; the aligned word is returned.
- **Load accept:** `data_out` ← array[index]. State stays IDLE.
- **STORE_WORD accept:** array[index] ← `data_in`. State stays IDLE. `data_out` holds its value.
- **STORE_BYTE / STORE_HBYTE accept:**
  - Latch index, lane, size and low data (`data_in[7:0]` or `data_in[15:0]`, always low-aligned on the bus).
  - Capture array[index] into `rmw_word`; go to RMW.
- **RMW cycle** (next edge): write back `rmw_word` with the addressed lane(s) replaced.
  - Byte: bits [8*lane+7 : 8*lane].
  - Half: lane 0 → [15:0]; lane 2 → [31:16].
  - Go to IDLE. Bus inputs are ignored in RMW.
- **Ordering:** a load issued right after a sub-word store is held off by `ready=0`, so it always sees merged data. No read-during-write forwarding is needed.
- **Reset:** state IDLE, `data_out`=0, `access_fault`=0, `ready`=1. Array contents are not reset. Reset asserted in RMW discards the pending write-back.

## Timing
- **Load:** request held in cycle N, accepted at edge N; `data_out` is valid from edge N until the next accepted load or fault. One-cycle latency; `ready` stays 1.
- **Word store:** array updated at edge N; a load accepted at edge N+1 returns the new value.
- **Sub-word store:**
  - `ready`=0 for exactly the one cycle between edges N and N+1.
  - Write-back happens at edge N+1; the next accept is at edge N+2 at earliest.
- **access_fault:** high for the cycle after the faulting edge only. Back-to-back faults keep it high.
- **Throughput:** one request per cycle, except one bubble after each sub-word store.

## Test plan
- **Reset, then word round trip:** `reset_n` low mid-cycle → `ready`=1, `data_out`=0 immediately. STORE_WORD 0xDEADBEEF @0x10, then load @0x10 → `data_out`=0xDEADBEEF one edge after the load accept.
- **Byte merge:** word 0x11223344 @0x20; STORE_BYTE `data_in`=0x000000AA @0x22 → `ready` low for exactly one cycle; then load @0x20 → 0x11AA3344.
- **Half merge and stall:** STORE_HBYTE 0x0000BEEF @0x26, with a load @0x24 presented in the same cycle as `ready`=0 → load not accepted until `ready`=1; it then returns upper half 0xBEEF with the lower half unchanged.
- **Faults:**
  - STORE_WORD @0x12 → `access_fault` pulse, memory unchanged.
  - STORE_HBYTE @0x21 → `access_fault` pulse, memory unchanged.
  - Load @`BASE_ADDR+DEPTH_WORDS*4` → `access_fault` pulse and `data_out`=0.
- **Reset during RMW:** STORE_BYTE 0xFF @0x30 onto 0x00000000, then assert `reset_n` before the RMW edge → after release, load @0x30 returns 0x00000000 and state is IDLE.
- **Back-to-back throughput:** 8 word stores, then 8 loads on consecutive cycles → `ready` never drops, and each load returns its written value one cycle after its accept edge.
